// File: rtl/exe_stage.sv
// exe_stage: ARM-subset execute stage; shifter/immediate Val2, ALU with NZCV status, branch resolve, EX/MEM register
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             mem_wb_en_in,
    input  logic             mem_r_en_in,
    input  logic             mem_w_en_in,
    input  logic [3:0]       exe_cmd,
    input  logic             b_in,
    input  logic             s_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] rn_val,
    input  logic [WIDTH-1:0] rm_val,
    input  logic             imm_in,
    input  logic [11:0]      shift_operand,
    input  logic [23:0]      signed_imm,
    input  logic [3:0]       dest_in,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_addr,
    output logic [3:0]       status,
    output logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] st_val,
    output logic [3:0]       dest_out,
    output logic             mem_wb_en_out,
    output logic             mem_r_en_out,
    output logic             mem_w_en_out
);
    logic [2*WIDTH-1:0] rot_imm, rot_rm;
    logic [WIDTH-1:0]   asr, shifted, val2, op_b, res;
    logic [4:0]         amt;
    logic [WIDTH:0]     sum;
    logic               arith, sub_op, cin, c_n, v_n, valid;

    assign branch_taken = b_in & ~freeze;
    assign branch_addr  = pc_in + {{(WIDTH-26){signed_imm[23]}}, signed_imm, 2'b00};

    // rotations use a doubled word so the bits falling off the bottom wrap into the top half
    always_comb begin
        amt     = shift_operand[11:7];
        rot_imm = {2{24'b0, shift_operand[7:0]}} >> {shift_operand[11:8], 1'b0};
        rot_rm  = {rm_val, rm_val} >> amt;
        asr     = $signed(rm_val) >>> amt;
        shifted = shift_operand[6:5] == 2'b00 ? rm_val << amt :
                  shift_operand[6:5] == 2'b01 ? rm_val >> amt :
                  shift_operand[6:5] == 2'b10 ? asr : rot_rm[WIDTH-1:0];
        val2    = imm_in ? rot_imm[WIDTH-1:0] :
                  (mem_r_en_in | mem_w_en_in) ? {{(WIDTH-12){1'b0}}, shift_operand} : shifted;
    end

    // subtraction is Rn + ~Val2 + cin, so one adder serves all four arithmetic commands
    always_comb begin
        arith  = exe_cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101};
        sub_op = exe_cmd inside {4'b0100, 4'b0101};
        cin    = exe_cmd == 4'b0100 ? 1'b1 : (exe_cmd == 4'b0011 || exe_cmd == 4'b0101) ? status[1] : 1'b0;
        op_b   = sub_op ? ~val2 : val2;
        sum    = {1'b0, rn_val} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
        valid  = 1'b1;
        c_n    = arith ? sum[WIDTH] : status[1];
        v_n    = arith ? (rn_val[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != rn_val[WIDTH-1]) : status[0];
        res    = '0;
        case (exe_cmd)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: res = sum[WIDTH-1:0];
            4'b0110: res = rn_val & val2;
            4'b0111: res = rn_val | val2;
            4'b1000: res = rn_val ^ val2;
            default: valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status        <= '0;
            alu_res       <= '0;
            st_val        <= '0;
            dest_out      <= '0;
            mem_wb_en_out <= 1'b0;
            mem_r_en_out  <= 1'b0;
            mem_w_en_out  <= 1'b0;
        end else if (!freeze) begin
            if (s_in && !b_in && valid)
                status <= {res[WIDTH-1], res == '0, c_n, v_n};
            alu_res       <= res;
            st_val        <= rm_val;
            dest_out      <= dest_in;
            mem_wb_en_out <= mem_wb_en_in;
            mem_r_en_out  <= mem_r_en_in;
            mem_w_en_out  <= mem_w_en_in;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors with hand-computed expectations for exe_stage
module tb_exe_stage;
    logic        clk = 1'b0, rst = 1'b0, freeze = 1'b0;
    logic        mem_wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
    logic [3:0]  exe_cmd = '0, dest_in = '0;
    logic        b_in = 1'b0, s_in = 1'b0, imm_in = 1'b0;
    logic [31:0] pc_in = '0, rn_val = '0, rm_val = '0;
    logic [11:0] shift_operand = '0;
    logic [23:0] signed_imm = '0;
    logic        branch_taken, mem_wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [31:0] branch_addr, alu_res, st_val;
    logic [3:0]  status, dest_out;
    int total = 0, bad = 0;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .mem_wb_en_in(mem_wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .exe_cmd(exe_cmd),
        .b_in(b_in), .s_in(s_in), .pc_in(pc_in), .rn_val(rn_val), .rm_val(rm_val),
        .imm_in(imm_in), .shift_operand(shift_operand), .signed_imm(signed_imm),
        .dest_in(dest_in), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .status(status), .alu_res(alu_res), .st_val(st_val), .dest_out(dest_out),
        .mem_wb_en_out(mem_wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] cmd, input logic s, input logic imm,
                         input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
        exe_cmd = cmd; s_in = s; imm_in = imm; shift_operand = so; rn_val = rn; rm_val = rm;
    endtask

    initial begin
        #2;
        chk("rst_status", {28'b0, status}, 32'h0);
        chk("rst_alu", alu_res, 32'h0);
        #10 rst = 1'b1;
        // subtract: equal operands, then borrow
        dest_in = 4'h3; mem_wb_en_in = 1'b1;
        issue(4'b0100, 1'b1, 1'b1, 12'h005, 32'd5, 32'h1234_5678);
        step();
        chk("sub_eq_res", alu_res, 32'h0);
        chk("sub_eq_st", {28'b0, status}, 32'h6);
        chk("sub_dest", {28'b0, dest_out}, 32'h3);
        chk("sub_wb", {31'b0, mem_wb_en_out}, 32'h1);
        chk("st_val", st_val, 32'h1234_5678);
        issue(4'b0100, 1'b1, 1'b1, 12'h005, 32'd3, 32'h0);
        step();
        chk("sub_neg_res", alu_res, 32'hFFFF_FFFE);
        chk("sub_neg_st", {28'b0, status}, 32'h8);
        // add overflow, then ADC with carry set by a prior compare
        issue(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0);
        step();
        chk("add_ovf_res", alu_res, 32'h8000_0000);
        chk("add_ovf_st", {28'b0, status}, 32'h9);
        issue(4'b0100, 1'b1, 1'b1, 12'h005, 32'd5, 32'h0);
        step();
        issue(4'b0011, 1'b1, 1'b1, 12'h001, 32'd1, 32'h0);
        step();
        chk("adc_res", alu_res, 32'd3);
        chk("adc_st", {28'b0, status}, 32'h0);
        issue(4'b0101, 1'b1, 1'b1, 12'h003, 32'd10, 32'h0);
        step();
        chk("sbc_res", alu_res, 32'd6);
        chk("sbc_st", {28'b0, status}, 32'h2);
        // logic ops keep C and V
        issue(4'b0110, 1'b1, 1'b1, 12'h0F0, 32'h0000_FF00, 32'h0);
        step();
        chk("and_res", alu_res, 32'h0);
        chk("and_st", {28'b0, status}, 32'h6);
        issue(4'b1001, 1'b1, 1'b1, 12'h000, 32'h0, 32'h0);
        step();
        chk("mvn_res", alu_res, 32'hFFFF_FFFF);
        chk("mvn_st", {28'b0, status}, 32'hA);
        issue(4'b0000, 1'b1, 1'b1, 12'h0FF, 32'h5, 32'h0);
        step();
        chk("nop_res", alu_res, 32'h0);
        chk("nop_st", {28'b0, status}, 32'hA);
        issue(4'b0111, 1'b0, 1'b1, 12'h00F, 32'h0000_00F0, 32'h0);
        step();
        chk("orr_res", alu_res, 32'h0000_00FF);
        issue(4'b1000, 1'b0, 1'b1, 12'h00F, 32'h0000_00FF, 32'h0);
        step();
        chk("eor_res", alu_res, 32'h0000_00F0);
        // Val2 forms through MOV
        issue(4'b0001, 1'b0, 1'b1, 12'h3FF, 32'h0, 32'h0);
        step();
        chk("imm_rot3", alu_res, 32'hFC00_0003);
        issue(4'b0001, 1'b0, 1'b1, 12'h2FF, 32'h0, 32'h0);
        step();
        chk("imm_rot2", alu_res, 32'hF000_000F);
        issue(4'b0001, 1'b0, 1'b0, 12'h240, 32'h0, 32'h8000_0000);
        step();
        chk("asr4", alu_res, 32'hF800_0000);
        issue(4'b0001, 1'b0, 1'b0, 12'h0E0, 32'h0, 32'h0000_0001);
        step();
        chk("ror1", alu_res, 32'h8000_0000);
        issue(4'b0001, 1'b0, 1'b0, 12'hFA0, 32'h0, 32'h8000_0000);
        step();
        chk("lsr31", alu_res, 32'h1);
        issue(4'b0001, 1'b0, 1'b0, 12'h040, 32'h0, 32'h8000_0000);
        step();
        chk("asr0", alu_res, 32'h8000_0000);
        issue(4'b0001, 1'b0, 1'b0, 12'h080, 32'h0, 32'h0000_0003);
        step();
        chk("lsl1", alu_res, 32'h6);
        mem_r_en_in = 1'b1;
        issue(4'b0010, 1'b0, 1'b0, 12'hABC, 32'h100, 32'hFFFF_FFFF);
        step();
        chk("mem_off", alu_res, 32'h0000_0BBC);
        chk("mem_r", {31'b0, mem_r_en_out}, 32'h1);
        mem_r_en_in = 1'b0;
        // branch: negative offset, wrap, no status update, freeze suppresses
        b_in = 1'b1; pc_in = 32'h100; signed_imm = 24'hFFFFFE;
        issue(4'b0100, 1'b1, 1'b1, 12'h005, 32'h0, 32'h0);
        #1;
        chk("br_addr", branch_addr, 32'h0000_00F8);
        chk("br_taken", {31'b0, branch_taken}, 32'h1);
        step();
        chk("br_st", {28'b0, status}, 32'hA);
        pc_in = 32'hFFFF_FFFC; signed_imm = 24'h000002;
        #1;
        chk("br_wrap", branch_addr, 32'h0000_0004);
        freeze = 1'b1;
        #1;
        chk("br_frz", {31'b0, branch_taken}, 32'h0);
        freeze = 1'b0; b_in = 1'b0;
        // freeze holds everything, release loads current inputs
        dest_in = 4'h5;
        issue(4'b0001, 1'b1, 1'b1, 12'h011, 32'h0, 32'h0);
        step();
        chk("pre_frz_res", alu_res, 32'h11);
        chk("pre_frz_st", {28'b0, status}, 32'h2);
        freeze = 1'b1; dest_in = 4'h6;
        issue(4'b1001, 1'b1, 1'b1, 12'h022, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_res", alu_res, 32'h11);
        end
        chk("frz_st", {28'b0, status}, 32'h2);
        chk("frz_dest", {28'b0, dest_out}, 32'h5);
        freeze = 1'b0;
        step();
        chk("unfrz_res", alu_res, 32'hFFFF_FFDD);
        chk("unfrz_st", {28'b0, status}, 32'hA);
        chk("unfrz_dest", {28'b0, dest_out}, 32'h6);
        // async reset mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("arst_st", {28'b0, status}, 32'h0);
        chk("arst_res", alu_res, 32'h0);
        chk("arst_dest", {28'b0, dest_out}, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
